// File: rtl/not16_bist_ctrl.sv
// Built-in self-test sweep controller for a WIDTH-bit bitwise inverter unit.
// Optional macro BIST_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module not16_bist_ctrl #(
   parameter int unsigned     WIDTH = 16,
   parameter logic [WIDTH-1:0] FIRST = '0,
   parameter logic [WIDTH-1:0] LAST  = '1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   output logic [WIDTH-1:0] dut_in,
   input  logic [WIDTH-1:0] dut_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [15:0]      err_count,
   output logic             fail_valid,
   output logic [WIDTH-1:0] fail_pattern
);

   localparam int unsigned CW = 16;
   localparam logic [CW-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] dut_in_nxt, fail_pattern_nxt;
   logic [CW-1:0]    err_count_nxt;
   logic             fail_valid_nxt, pass_nxt;
   logic             mismatch;

   assign mismatch = (dut_out != ~dut_in);

   // State register; outputs register the next-state view so they line up with state
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         dut_in       <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         pass         <= 1'b0;
         err_count    <= '0;
         fail_valid   <= 1'b0;
         fail_pattern <= '0;
      end else begin
         state        <= state_nxt;
         dut_in       <= dut_in_nxt;
         busy         <= (state_nxt == S_RUN);
         done         <= (state_nxt == S_DONE);
         pass         <= pass_nxt;
         err_count    <= err_count_nxt;
         fail_valid   <= fail_valid_nxt;
         fail_pattern <= fail_pattern_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (start) state_nxt = S_RUN;
         S_RUN: begin
            if (abort) begin
               state_nxt = S_IDLE;
`ifdef BIST_STOP_ON_FAIL_EN
            end else if (mismatch) begin
               state_nxt = S_DONE;
`endif
            end else if (dut_in == LAST) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: if (start) state_nxt = S_RUN;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Datapath next values: sweep pattern, error accounting, verdict
   always_comb begin
      dut_in_nxt       = dut_in;
      err_count_nxt    = err_count;
      fail_valid_nxt   = fail_valid;
      fail_pattern_nxt = fail_pattern;
      pass_nxt         = pass;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               dut_in_nxt       = FIRST;
               err_count_nxt    = '0;
               fail_valid_nxt   = 1'b0;
               fail_pattern_nxt = '0;
               pass_nxt         = 1'b0;
            end
         end
         S_RUN: begin
            // An aborted cycle's compare is discarded entirely
            if (!abort) begin
               if (mismatch) begin
                  if (err_count != CNT_MAX) err_count_nxt = err_count + CW'(1);
                  if (!fail_valid) begin
                     fail_valid_nxt   = 1'b1;
                     fail_pattern_nxt = dut_in;
                  end
               end
               if (state_nxt == S_DONE) begin
                  pass_nxt = (err_count_nxt == '0);
               end else begin
                  dut_in_nxt = dut_in + WIDTH'(1);
               end
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_not16_bist_ctrl.sv
// Scoreboard bench: three controller instances with differing sweep ranges and a
// fault-injecting model of the inverter on each.
module tb_not16_bist_ctrl;

   localparam int unsigned NI = 3;
   localparam logic [15:0] MID_FIRST = 16'h00F0;
   localparam logic [15:0] MID_LAST  = 16'h0110;

   logic        clk;
   logic        reset;
   logic        start        [NI];
   logic        abort        [NI];
   logic [15:0] dut_in       [NI];
   logic [15:0] dut_out      [NI];
   logic        busy         [NI];
   logic        done         [NI];
   logic        pass         [NI];
   logic [15:0] err_count    [NI];
   logic        fail_valid   [NI];
   logic [15:0] fail_pattern [NI];
   int          fmode        [NI];

   int checks = 0;
   int errors = 0;

   // 0: ideal inverter, 1: bit 3 stuck at 0, 2: pass-through
   function automatic logic [15:0] resp(input int mode, input logic [15:0] x);
      case (mode)
         1:       resp = ~x & 16'hFFF7;
         2:       resp = x;
         default: resp = ~x;
      endcase
   endfunction

   always_comb begin
      for (int k = 0; k < NI; k++) dut_out[k] = resp(fmode[k], dut_in[k]);
   end

   not16_bist_ctrl u_full (
      .clk(clk), .reset(reset), .start(start[0]), .abort(abort[0]),
      .dut_in(dut_in[0]), .dut_out(dut_out[0]), .busy(busy[0]), .done(done[0]),
      .pass(pass[0]), .err_count(err_count[0]), .fail_valid(fail_valid[0]),
      .fail_pattern(fail_pattern[0]));

   not16_bist_ctrl #(.WIDTH(16), .FIRST(16'hFFFE), .LAST(16'h0001)) u_wrap (
      .clk(clk), .reset(reset), .start(start[1]), .abort(abort[1]),
      .dut_in(dut_in[1]), .dut_out(dut_out[1]), .busy(busy[1]), .done(done[1]),
      .pass(pass[1]), .err_count(err_count[1]), .fail_valid(fail_valid[1]),
      .fail_pattern(fail_pattern[1]));

   not16_bist_ctrl #(.WIDTH(16), .FIRST(MID_FIRST), .LAST(MID_LAST)) u_mid (
      .clk(clk), .reset(reset), .start(start[2]), .abort(abort[2]),
      .dut_in(dut_in[2]), .dut_out(dut_out[2]), .busy(busy[2]), .done(done[2]),
      .pass(pass[2]), .err_count(err_count[2]), .fail_valid(fail_valid[2]),
      .fail_pattern(fail_pattern[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Checks every output of instance i against its reset value
   task automatic check_idle_reset(input int i, input string tag);
      checks++;
      if (busy[i] !== 1'b0 || done[i] !== 1'b0 || pass[i] !== 1'b0 || fail_valid[i] !== 1'b0) begin
         errors++;
         $display("FAIL %s[%0d] flags: busy=%b done=%b pass=%b fv=%b, required all 0",
                  tag, i, busy[i], done[i], pass[i], fail_valid[i]);
      end
      checks++;
      if (dut_in[i] !== 16'h0 || err_count[i] !== 16'h0 || fail_pattern[i] !== 16'h0) begin
         errors++;
         $display("FAIL %s[%0d] data: dut_in=%h err=%h fp=%h, required all 0",
                  tag, i, dut_in[i], err_count[i], fail_pattern[i]);
      end
   endtask

   task automatic wait_pattern(input int i, input logic [15:0] target);
      int cyc = 0;
      while (dut_in[i] !== target && busy[i] === 1'b1 && cyc < 70000) begin
         step();
         cyc++;
      end
      checks++;
      if (dut_in[i] !== target || busy[i] !== 1'b1) begin
         errors++;
         $display("FAIL wait_pattern[%0d]: dut_in=%h busy=%b, required %h in RUN",
                  i, dut_in[i], busy[i], target);
      end
   endtask

   // Launches a sweep on instance i and scores every pattern plus the final verdict
   task automatic run_sweep(input int i, input logic [15:0] first, input logic [15:0] last,
                            input int mode, input bit hold_start, input string tag);
      logic [15:0] q[$];
      logic [15:0] p, hold_m, got_exp;
      int          n_exp, cyc;
      int unsigned err_m;
      logic        fv_m;
      logic [15:0] fp_m;
      fmode[i] = mode;
      p = first; n_exp = 0; err_m = 0; fv_m = 1'b0; fp_m = 16'h0; hold_m = first;
      while (1) begin
         q.push_back(p);
         n_exp++;
         hold_m = p;
         if (resp(mode, p) !== ~p) begin
            if (err_m != 32'd65535) err_m++;
            if (!fv_m) begin fv_m = 1'b1; fp_m = p; end
`ifdef BIST_STOP_ON_FAIL_EN
            break;
`endif
         end
         if (p == last) break;
         p = p + 16'd1;
      end

      start[i] = 1'b1;
      step();
      if (!hold_start) start[i] = 1'b0;
      checks++;
      if (busy[i] !== 1'b1 || done[i] !== 1'b0 || err_count[i] !== 16'h0 ||
          fail_valid[i] !== 1'b0 || fail_pattern[i] !== 16'h0) begin
         errors++;
         $display("FAIL %s launch: busy=%b done=%b err=%h fv=%b fp=%h, required 1 0 0 0 0",
                  tag, busy[i], done[i], err_count[i], fail_valid[i], fail_pattern[i]);
      end

      cyc = 0;
      while (busy[i] === 1'b1 && cyc < n_exp + 4) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL %s extra_pattern: dut_in=%h, required sweep already ended", tag, dut_in[i]);
         end else begin
            got_exp = q.pop_front();
            if (dut_in[i] !== got_exp) begin
               errors++;
               $display("FAIL %s pattern: dut_in=%h, required %h", tag, dut_in[i], got_exp);
            end
         end
         step();
         cyc++;
      end
      start[i] = 1'b0;

      checks++;
      if (cyc != n_exp || q.size() != 0) begin
         errors++;
         $display("FAIL %s run_length: cycles=%0d left=%0d, required %0d cycles", tag, cyc, q.size(), n_exp);
      end
      checks++;
      if (done[i] !== 1'b1 || busy[i] !== 1'b0 || pass[i] !== (err_m == 0)) begin
         errors++;
         $display("FAIL %s verdict: done=%b busy=%b pass=%b, required 1 0 %b",
                  tag, done[i], busy[i], pass[i], (err_m == 0));
      end
      checks++;
      if (err_count[i] !== 16'(err_m) || fail_valid[i] !== fv_m || fail_pattern[i] !== fp_m) begin
         errors++;
         $display("FAIL %s capture: err=%h fv=%b fp=%h, required %h %b %h",
                  tag, err_count[i], fail_valid[i], fail_pattern[i], 16'(err_m), fv_m, fp_m);
      end
      checks++;
      if (dut_in[i] !== hold_m) begin
         errors++;
         $display("FAIL %s hold: dut_in=%h, required %h", tag, dut_in[i], hold_m);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < NI; i++) begin start[i] = 1'b0; abort[i] = 1'b0; fmode[i] = 0; end
      step();
      step();
      reset = 1'b0;
      for (int i = 0; i < NI; i++) check_idle_reset(i, "reset");
      abort[2] = 1'b1;
      step();
      abort[2] = 1'b0;
      check_idle_reset(2, "abort_in_idle");
   endtask

   task automatic test_wrap();
      run_sweep(1, 16'hFFFE, 16'h0001, 0, 1'b0, "wrap_ideal");
      run_sweep(1, 16'hFFFE, 16'h0001, 1, 1'b0, "wrap_stuck3");
   endtask

   task automatic test_stuck_mid();
      run_sweep(2, MID_FIRST, MID_LAST, 0, 1'b0, "mid_ideal");
      run_sweep(2, MID_FIRST, MID_LAST, 1, 1'b0, "mid_stuck3");
   endtask

   task automatic test_abort();
      int unsigned err_m = 0;
      logic        fv_m  = 1'b0;
      logic [15:0] fp_m  = 16'h0;
`ifdef BIST_STOP_ON_FAIL_EN
      fmode[2] = 0;
`else
      fmode[2] = 1;
`endif
      for (logic [15:0] p = MID_FIRST; p != 16'h0100; p++) begin
         if (resp(fmode[2], p) !== ~p) begin
            err_m++;
            if (!fv_m) begin fv_m = 1'b1; fp_m = p; end
         end
      end
      start[2] = 1'b1;
      step();
      start[2] = 1'b0;
      wait_pattern(2, 16'h0100);
      abort[2] = 1'b1;
      step();
      abort[2] = 1'b0;
      checks++;
      if (busy[2] !== 1'b0 || done[2] !== 1'b0) begin
         errors++;
         $display("FAIL abort state: busy=%b done=%b, required 0 0", busy[2], done[2]);
      end
      checks++;
      if (err_count[2] !== 16'(err_m) || fail_valid[2] !== fv_m || fail_pattern[2] !== fp_m) begin
         errors++;
         $display("FAIL abort hold: err=%h fv=%b fp=%h, required %h %b %h",
                  err_count[2], fail_valid[2], fail_pattern[2], 16'(err_m), fv_m, fp_m);
      end
      step();
      checks++;
      if (busy[2] !== 1'b0 || done[2] !== 1'b0) begin
         errors++;
         $display("FAIL abort stays_idle: busy=%b done=%b, required 0 0", busy[2], done[2]);
      end
      run_sweep(2, MID_FIRST, MID_LAST, 0, 1'b0, "after_abort");
   endtask

   task automatic test_reset_mid();
      fmode[2] = 1;
      start[2] = 1'b1;
      step();
      start[2] = 1'b0;
      wait_pattern(2, 16'h00F4);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_idle_reset(2, "reset_mid");
      step();
      check_idle_reset(2, "reset_mid_after");
   endtask

   task automatic test_back_to_back();
      run_sweep(2, MID_FIRST, MID_LAST, 0, 1'b1, "start_held");
      run_sweep(2, MID_FIRST, MID_LAST, 1, 1'b0, "restart_from_done");
   endtask

   task automatic test_saturation();
      run_sweep(0, 16'h0000, 16'hFFFF, 2, 1'b0, "full_passthru");
   endtask

   initial begin
      reset = 1'b1;
      test_reset();
      test_wrap();
      test_stuck_mid();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
